// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The optional HAZARD_PERF_CNT_EN build adds performance counters; their width is fixed here.
package pipeline_pkg;

    localparam int unsigned REG_W              = 5;
    localparam logic [REG_W-1:0] REG_ZERO      = 5'd0;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 64;
    localparam int unsigned CNT_W_DEF          = 16;
    localparam int unsigned PERF_CNT_W         = CNT_W_DEF;

    typedef enum logic [0:0] {RUN = 1'b0, MEM_WAIT = 1'b1} hz_state_t;

    // Stall/flush bundle produced by the hazard priority logic
    typedef struct packed {
        logic pc_src;
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_m;
        logic flush_w;
    } hz_ctrl_t;

    // A load in EX whose destination feeds the instruction in ID; x0 never conflicts
    function automatic logic is_load_use(input logic             mem_read,
                                         input logic [REG_W-1:0] rd,
                                         input logic [REG_W-1:0] rs1,
                                         input logic [REG_W-1:0] rs2);
        return mem_read && (rd != REG_ZERO) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle between the core datapath (master) and the controller (slave).
// Counter outputs exist only when HAZARD_PERF_CNT_EN is defined.
interface pipeline_hazard_ctrl_if;
    import pipeline_pkg::*;

    logic [REG_W-1:0] rs1D;
    logic [REG_W-1:0] rs2D;
    logic [REG_W-1:0] rdE;
    logic             memReadE;
    logic             memReadM;
    logic             memWriteM;
    logic             branchTakenM;
    logic             dmemReady;
    logic             dmemReq;
    logic             pcSrcF;
    logic             stallF;
    logic             stallD;
    logic             stallE;
    logic             stallM;
    logic             flushD;
    logic             flushE;
    logic             flushM;
    logic             flushW;
    logic             memTimeout;
    logic             waitBusy;
`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] loadUseCnt;
    logic [PERF_CNT_W-1:0] memWaitCnt;
    logic [PERF_CNT_W-1:0] flushCnt;
`endif

    modport master (
        output rs1D, rs2D, rdE, memReadE, memReadM, memWriteM, branchTakenM, dmemReady,
        input  dmemReq, pcSrcF, stallF, stallD, stallE, stallM,
        input  flushD, flushE, flushM, flushW, memTimeout, waitBusy
`ifdef HAZARD_PERF_CNT_EN
        , input loadUseCnt, memWaitCnt, flushCnt
`endif
    );

    modport slave (
        input  rs1D, rs2D, rdE, memReadE, memReadM, memWriteM, branchTakenM, dmemReady,
        output dmemReq, pcSrcF, stallF, stallD, stallE, stallM,
        output flushD, flushE, flushM, flushW, memTimeout, waitBusy
`ifdef HAZARD_PERF_CNT_EN
        , output loadUseCnt, memWaitCnt, flushCnt
`endif
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_mem_wait_fsm.sv
// Data-memory wait sequencer: RUN/MEM_WAIT state, saturating wait counter and
// sticky timeout watchdog. The FSM never aborts an access on timeout.
module mem_wait_fsm
    import pipeline_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned CNT_W          = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_acc,
    input  logic dmem_ready,
    output logic dmem_req_c,
    output logic mem_stall_c,
    output logic wait_busy,
    output logic mem_timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    hz_state_t        state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic             timeout_nxt;

    // State, wait counter and sticky timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            mem_timeout <= timeout_nxt;
        end
    end

    // Next state; a stall covers the first RUN miss cycle and every unready MEM_WAIT cycle
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = '0;
        timeout_nxt  = mem_timeout;
        mem_stall_c  = 1'b0;
        case (state)
            RUN: begin
                if (mem_acc && !dmem_ready) begin
                    mem_stall_c = 1'b1;
                    state_nxt   = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_nxt = RUN;
                end else begin
                    mem_stall_c = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
        if (mem_stall_c) begin
            wait_cnt_nxt = (wait_cnt != '1) ? wait_cnt + CNT_W'(1) : wait_cnt;
            if (wait_cnt >= TIMEOUT_LAST) begin
                timeout_nxt = 1'b1;
            end
        end
        if (!rst) begin
            mem_stall_c = 1'b0;
        end
    end

    assign dmem_req_c = rst && mem_acc;
    assign wait_busy  = (state == MEM_WAIT);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage core: memory wait > taken branch > load-use.
// Define HAZARD_PERF_CNT_EN to add saturating load-use / memory-stall / flush counters.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned CNT_W          = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    logic     mem_acc_c;
    logic     mem_stall_c;
    logic     load_use_c;
    logic     lu_stall_c;
    logic     br_flush_c;
    hz_ctrl_t ctrl_c;

    assign mem_acc_c  = hz.memReadM || hz.memWriteM;
    assign load_use_c = is_load_use(hz.memReadE, hz.rdE, hz.rs1D, hz.rs2D);

    mem_wait_fsm #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_fsm (
        .clk        (clk),
        .rst        (rst),
        .mem_acc    (mem_acc_c),
        .dmem_ready (hz.dmemReady),
        .dmem_req_c (hz.dmemReq),
        .mem_stall_c(mem_stall_c),
        .wait_busy  (hz.waitBusy),
        .mem_timeout(hz.memTimeout)
    );

    // Priority decode; everything reads 0 while reset is asserted
    always_comb begin
        ctrl_c     = '0;
        lu_stall_c = 1'b0;
        br_flush_c = 1'b0;
        if (rst) begin
            if (mem_stall_c) begin
                ctrl_c.stall_f = 1'b1;
                ctrl_c.stall_d = 1'b1;
                ctrl_c.stall_e = 1'b1;
                ctrl_c.stall_m = 1'b1;
                ctrl_c.flush_w = 1'b1;
            end else if (hz.branchTakenM) begin
                br_flush_c     = 1'b1;
                ctrl_c.pc_src  = 1'b1;
                ctrl_c.flush_d = 1'b1;
                ctrl_c.flush_e = 1'b1;
                ctrl_c.flush_m = 1'b1;
            end else if (load_use_c) begin
                lu_stall_c     = 1'b1;
                ctrl_c.stall_f = 1'b1;
                ctrl_c.stall_d = 1'b1;
                ctrl_c.flush_e = 1'b1;
            end
        end
    end

    assign hz.pcSrcF = ctrl_c.pc_src;
    assign hz.stallF = ctrl_c.stall_f;
    assign hz.stallD = ctrl_c.stall_d;
    assign hz.stallE = ctrl_c.stall_e;
    assign hz.stallM = ctrl_c.stall_m;
    assign hz.flushD = ctrl_c.flush_d;
    assign hz.flushE = ctrl_c.flush_e;
    assign hz.flushM = ctrl_c.flush_m;
    assign hz.flushW = ctrl_c.flush_w;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] load_use_cnt;
    logic [CNT_W-1:0] mem_wait_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Saturating event counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_use_cnt <= '0;
            mem_wait_cnt <= '0;
            flush_cnt    <= '0;
        end else begin
            if (lu_stall_c && (load_use_cnt != '1)) load_use_cnt <= load_use_cnt + CNT_W'(1);
            if (mem_stall_c && (mem_wait_cnt != '1)) mem_wait_cnt <= mem_wait_cnt + CNT_W'(1);
            if (br_flush_c && (flush_cnt != '1))     flush_cnt    <= flush_cnt + CNT_W'(1);
        end
    end

    assign hz.loadUseCnt = PERF_CNT_W'(load_use_cnt);
    assign hz.memWaitCnt = PERF_CNT_W'(mem_wait_cnt);
    assign hz.flushCnt   = PERF_CNT_W'(flush_cnt);
`endif

`ifndef SYNTHESIS
    // A single instruction cannot both branch and access memory in MEM
    a_branch_mem_excl: assert property (@(posedge clk) disable iff (!rst)
                                        !(hz.branchTakenM && mem_acc_c))
        else $error("branchTakenM asserted together with a memory access in MEM");
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: the driver queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;

    localparam logic [11:0] E_REQ = 12'h800;
    localparam logic [11:0] E_PC  = 12'h400;
    localparam logic [11:0] E_SF  = 12'h200;
    localparam logic [11:0] E_SD  = 12'h100;
    localparam logic [11:0] E_SE  = 12'h080;
    localparam logic [11:0] E_SM  = 12'h040;
    localparam logic [11:0] E_FD  = 12'h020;
    localparam logic [11:0] E_FE  = 12'h010;
    localparam logic [11:0] E_FM  = 12'h008;
    localparam logic [11:0] E_FW  = 12'h004;
    localparam logic [11:0] E_TO  = 12'h002;
    localparam logic [11:0] E_WB  = 12'h001;
    localparam logic [11:0] E_LU  = E_SF | E_SD | E_FE;
    localparam logic [11:0] E_MS  = E_REQ | E_SF | E_SD | E_SE | E_SM | E_FW;
    localparam logic [11:0] E_BR  = E_PC | E_FD | E_FE | E_FM;

    typedef struct {
        string       name;
        logic [11:0] exp;
        int          cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    pipeline_hazard_ctrl_if hz ();

    pipeline_hazard_ctrl #(
        .TIMEOUT_CYCLES(4),
        .CNT_W         (16)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .hz (hz)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] observe();
        return {hz.dmemReq, hz.pcSrcF, hz.stallF, hz.stallD, hz.stallE, hz.stallM,
                hz.flushD, hz.flushE, hz.flushM, hz.flushW, hz.memTimeout, hz.waitBusy};
    endfunction

    // Monitor: compare the outputs of the current cycle against the queued expectation
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            logic [11:0] act;
            int cnt_act;
            e   = sb_q.pop_front();
            act = observe();
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: outputs got %03h expected %03h", e.name, act, e.exp);
            end
            if (e.cnt >= 0) begin
                cnt_act = int'(u_dut.u_fsm.wait_cnt);
                checks++;
                if (cnt_act != e.cnt) begin
                    errors++;
                    $display("FAIL %s_waitcnt: got %0d expected %0d", e.name, cnt_act, e.cnt);
                end
            end
        end
    end

    task automatic step(input string nm, input logic r,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic mre, input logic mrm, input logic mwm,
                        input logic bt, input logic rdy,
                        input logic [11:0] exp, input int cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = r;
        hz.rs1D         = rs1;
        hz.rs2D         = rs2;
        hz.rdE          = rd;
        hz.memReadE     = mre;
        hz.memReadM     = mrm;
        hz.memWriteM    = mwm;
        hz.branchTakenM = bt;
        hz.dmemReady    = rdy;
        e.name = nm;
        e.exp  = exp;
        e.cnt  = cnt;
        sb_q.push_back(e);
    endtask

    task automatic chk_val(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        hz.rs1D = '0; hz.rs2D = '0; hz.rdE = '0;
        hz.memReadE = 1'b0; hz.memReadM = 1'b0; hz.memWriteM = 1'b0;
        hz.branchTakenM = 1'b0; hz.dmemReady = 1'b0;

        // In reset: load-use and a pending load must not leak to the outputs
        step("in_reset",   1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 0);
        step("idle",       1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 0);
        step("lu_rs1",     1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, E_LU, 0);
        step("lu_rd0",     1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 0);
        step("lu_rs2",     1'b1, 5'd3, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, E_LU, 0);
        step("no_load",    1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 0);

        // Three-cycle memory wait with a masked load-use
        step("wait_c1",    1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_MS, 0);
        step("wait_c2",    1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_MS | E_WB, 1);
        step("wait_c3",    1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_MS | E_WB, 2);
        step("wait_done",  1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, E_REQ | E_WB, 3);
        step("wait_after", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 0);
`ifdef HAZARD_PERF_CNT_EN
        @(posedge clk);
        #2;
        chk_val("perf_load_use", int'(hz.loadUseCnt), 2);
        chk_val("perf_mem_wait", int'(hz.memWaitCnt), 3);
        chk_val("perf_flush",    int'(hz.flushCnt),   0);
`endif

        // Branch overrides load-use; then a plain branch; then a single-cycle store
        step("br_lu",      1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, E_BR, 0);
        step("br_only",    1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_BR, 0);
        step("store_1cyc", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, E_REQ, 0);
        step("store_aft",  1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 0);

        // Watchdog: TIMEOUT_CYCLES=4 with dmemReady held low
        step("to_c1",      1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_MS, 0);
        step("to_c2",      1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_MS | E_WB, 1);
        step("to_c3",      1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_MS | E_WB, 2);
        step("to_c4",      1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_MS | E_WB, 3);
        step("to_c5",      1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_MS | E_WB | E_TO, 4);
        step("to_done",    1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, E_REQ | E_WB | E_TO, 5);
        step("to_sticky",  1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, E_TO, 0);

        // Asynchronous reset in the middle of a wait, then a single-cycle store
        step("rst_c1",     1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_MS | E_TO, 0);
        step("rst_c2",     1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_MS | E_WB | E_TO, 1);
        step("rst_mid",    1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 0);
        step("rst_store",  1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, E_REQ, 0);
        step("rst_idle",   1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
